// File: rtl/spatz_tcdm_pkg.sv
// Shared types for the TCDM bank adapter.
//   - amo_op_e    : atomic opcode carried on the request; the encoding mirrors
//                   reqrsp_pkg::amo_op_e so requests pass through unchanged.
//   - amo_state_e : bank adapter FSM states.
//   - amo_lane_e  : operand lane decoded from the byte strobes.
//   - mem_req_t / mem_rsp_t : interconnect output-port request/response.
package spatz_tcdm_pkg;

   localparam int unsigned AddrWidth = 10;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned HalfWidth = DataWidth / 2;

   typedef enum logic [3:0] {
      AMONone = 4'h0,
      AMOSwap = 4'h1,
      AMOAdd  = 4'h2,
      AMOAnd  = 4'h3,
      AMOOr   = 4'h4,
      AMOXor  = 4'h5,
      AMOMax  = 4'h6,
      AMOMaxu = 4'h7,
      AMOMin  = 4'h8,
      AMOMinu = 4'h9,
      AMOLR   = 4'hA,
      AMOSC   = 4'hB
   } amo_op_e;

   typedef enum logic {
      Idle = 1'b0,
      Amo  = 1'b1
   } amo_state_e;

   typedef enum logic [1:0] {
      LaneLo   = 2'd0,
      LaneHi   = 2'd1,
      LaneFull = 2'd2,
      LaneBad  = 2'd3
   } amo_lane_e;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic                 write;
      amo_op_e              amo;
      logic [DataWidth-1:0] data;
      logic [StrbWidth-1:0] strb;
      logic                 user;
   } mem_req_chan_t;

   typedef struct packed {
      logic          q_valid;
      mem_req_chan_t q;
   } mem_req_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
   } mem_rsp_chan_t;

   typedef struct packed {
      logic          q_ready;
      mem_rsp_chan_t p;
   } mem_rsp_t;

   // Only whole 32-bit lanes or the full word are legal atomic widths.
   function automatic amo_lane_e lane_from_strb(input logic [StrbWidth-1:0] strb);
      amo_lane_e lane;
      case (strb)
         8'h0F:   lane = LaneLo;
         8'hF0:   lane = LaneHi;
         8'hFF:   lane = LaneFull;
         default: lane = LaneBad;
      endcase
      return lane;
   endfunction

   // True for the opcodes that need a read-modify-write cycle.
   function automatic logic is_rmw_op(input amo_op_e op);
      logic rmw;
      case (op)
         AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
         AMOMax, AMOMaxu, AMOMin, AMOMinu: rmw = 1'b1;
         default:                          rmw = 1'b0;
      endcase
      return rmw;
   endfunction

endpackage

// File: rtl/spatz_amo_alu.sv
// Combinational atomic ALU.
//   op_i      : atomic opcode (Swap/Add/And/Or/Xor/Max/Maxu/Min/Minu)
//   lane_i    : LaneLo / LaneHi select a 32-bit lane, LaneFull the 64-bit word
//   old_i     : word read from the SRAM
//   operand_i : request data, lane-aligned like the strobes
//   new_o     : word to write back; bytes outside the lane keep old_i
module spatz_amo_alu
   import spatz_tcdm_pkg::*;
(
   input  amo_op_e              op_i,
   input  amo_lane_e            lane_i,
   input  logic [DataWidth-1:0] old_i,
   input  logic [DataWidth-1:0] operand_i,
   output logic [DataWidth-1:0] new_o
);

   logic [DataWidth-1:0] a_s;
   logic [DataWidth-1:0] b_s;
   logic                 is_signed_s;
   logic [DataWidth:0]   a_ext_s;
   logic [DataWidth:0]   b_ext_s;
   logic                 a_lt_b_s;
   logic [DataWidth-1:0] res_s;

   // Shift the active lane down to bit 0 and widen by one bit so a single
   // signed compare serves both the signed and unsigned min/max variants.
   always_comb begin
      is_signed_s = (op_i == AMOMax) || (op_i == AMOMin);
      case (lane_i)
         LaneLo: begin
            a_s = {{HalfWidth{1'b0}}, old_i[HalfWidth-1:0]};
            b_s = {{HalfWidth{1'b0}}, operand_i[HalfWidth-1:0]};
         end
         LaneHi: begin
            a_s = {{HalfWidth{1'b0}}, old_i[DataWidth-1:HalfWidth]};
            b_s = {{HalfWidth{1'b0}}, operand_i[DataWidth-1:HalfWidth]};
         end
         default: begin
            a_s = old_i;
            b_s = operand_i;
         end
      endcase
      if (lane_i == LaneFull || lane_i == LaneBad) begin
         a_ext_s = {is_signed_s & a_s[DataWidth-1], a_s};
         b_ext_s = {is_signed_s & b_s[DataWidth-1], b_s};
      end else begin
         a_ext_s = {{(HalfWidth+1){is_signed_s & a_s[HalfWidth-1]}}, a_s[HalfWidth-1:0]};
         b_ext_s = {{(HalfWidth+1){is_signed_s & b_s[HalfWidth-1]}}, b_s[HalfWidth-1:0]};
      end
      a_lt_b_s = $signed(a_ext_s) < $signed(b_ext_s);
   end

   // Operation on the lane-aligned operands.
   always_comb begin
      case (op_i)
         AMOSwap:         res_s = b_s;
         AMOAdd:          res_s = a_s + b_s;
         AMOAnd:          res_s = a_s & b_s;
         AMOOr:           res_s = a_s | b_s;
         AMOXor:          res_s = a_s ^ b_s;
         AMOMax, AMOMaxu: res_s = a_lt_b_s ? b_s : a_s;
         AMOMin, AMOMinu: res_s = a_lt_b_s ? a_s : b_s;
         default:         res_s = b_s;
      endcase
   end

   // Put the lane result back into its position in the old word.
   always_comb begin
      case (lane_i)
         LaneLo:  new_o = {old_i[DataWidth-1:HalfWidth], res_s[HalfWidth-1:0]};
         LaneHi:  new_o = {res_s[HalfWidth-1:0], old_i[HalfWidth-1:0]};
         default: new_o = res_s;
      endcase
   end

endmodule

// File: rtl/spatz_tcdm_amo_bank_checker.sv
// Protocol checker for the bank adapter.
//   clk_i, rst_ni : bank clock and reset
//   amo_hs_i      : accepted request carrying an atomic opcode
//   strb_i        : byte strobes of that request
module spatz_tcdm_amo_bank_checker
   import spatz_tcdm_pkg::*;
(
   input logic                 clk_i,
   input logic                 rst_ni,
   input logic                 amo_hs_i,
   input logic [StrbWidth-1:0] strb_i
);

   // Atomics operate on a whole 32-bit lane or the full word only.
   a_amo_strb_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      amo_hs_i |-> (strb_i inside {8'h0F, 8'hF0, 8'hFF}));

endmodule

// File: rtl/spatz_tcdm_amo_bank.sv
// TCDM bank adapter: turns one interconnect request into single-port SRAM
// accesses, executes AMOs as read-modify-write and LR/SC with one reservation,
// and returns every response exactly one cycle after its handshake.
//   clk_i / rst_ni      : clock, asynchronous active-low reset
//   mem_req_i           : {q_valid, q{addr,write,amo,data,strb,user}}
//   mem_rsp_o           : {q_ready, p{data}}
//   sram_req_o/we_o     : SRAM enable / write enable
//   sram_addr_o         : SRAM word address
//   sram_wdata_o/be_o   : SRAM write data / byte enables
//   sram_rdata_i        : SRAM read data, one cycle after a read
module spatz_tcdm_amo_bank #(
   parameter int unsigned AddrWidth = spatz_tcdm_pkg::AddrWidth,
   parameter int unsigned DataWidth = spatz_tcdm_pkg::DataWidth,
   parameter type         mem_req_t = spatz_tcdm_pkg::mem_req_t,
   parameter type         mem_rsp_t = spatz_tcdm_pkg::mem_rsp_t,
   localparam int unsigned StrbWidth = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  mem_req_t             mem_req_i,
   output mem_rsp_t             mem_rsp_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [StrbWidth-1:0] sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);

   import spatz_tcdm_pkg::*;

   amo_state_e           state_q, state_d;
   logic                 resv_valid_q, resv_valid_d;
   logic [AddrWidth-1:0] resv_addr_q, resv_addr_d;
   logic                 sc_result_q, sc_result_d;
   logic                 sel_sc_q, sel_sc_d;
   logic [AddrWidth-1:0] amo_addr_q, amo_addr_d;
   logic [StrbWidth-1:0] amo_strb_q, amo_strb_d;
   logic [DataWidth-1:0] amo_operand_q, amo_operand_d;
   amo_op_e              amo_op_q, amo_op_d;
   amo_lane_e            amo_lane_q, amo_lane_d;

   logic                 hs_s;
   logic                 resv_hit_s;
   amo_lane_e            req_lane_s;
   logic [DataWidth-1:0] alu_new_s;
   logic                 unused_user_s;

   assign hs_s          = mem_req_i.q_valid & (state_q == Idle);
   assign resv_hit_s    = resv_valid_q & (resv_addr_q == mem_req_i.q.addr);
   assign req_lane_s    = lane_from_strb(mem_req_i.q.strb);
   assign unused_user_s = mem_req_i.q.user;

   spatz_amo_alu i_amo_alu (
      .op_i      (amo_op_q),
      .lane_i    (amo_lane_q),
      .old_i     (sram_rdata_i),
      .operand_i (amo_operand_q),
      .new_o     (alu_new_s)
   );

   spatz_tcdm_amo_bank_checker i_checker (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .amo_hs_i (hs_s & (mem_req_i.q.amo != AMONone)),
      .strb_i   (mem_req_i.q.strb)
   );

   // FSM next state, SRAM port drive and reservation tracking.
   always_comb begin
      state_d       = state_q;
      resv_valid_d  = resv_valid_q;
      resv_addr_d   = resv_addr_q;
      sc_result_d   = sc_result_q;
      sel_sc_d      = sel_sc_q;
      amo_addr_d    = amo_addr_q;
      amo_strb_d    = amo_strb_q;
      amo_operand_d = amo_operand_q;
      amo_op_d      = amo_op_q;
      amo_lane_d    = amo_lane_q;
      sram_req_o    = 1'b0;
      sram_we_o     = 1'b0;
      sram_addr_o   = '0;
      sram_wdata_o  = '0;
      sram_be_o     = '0;

      case (state_q)
         Idle: begin
            if (hs_s) begin
               sram_req_o   = 1'b1;
               sram_addr_o  = mem_req_i.q.addr;
               sram_wdata_o = mem_req_i.q.data;
               sram_be_o    = mem_req_i.q.strb;
               sel_sc_d     = 1'b0;
               case (mem_req_i.q.amo)
                  AMONone: begin
                     sram_we_o = mem_req_i.q.write;
                     if (mem_req_i.q.write && resv_hit_s) begin
                        resv_valid_d = 1'b0;
                     end else begin
                        resv_valid_d = resv_valid_q;
                     end
                  end
                  AMOLR: begin
                     resv_valid_d = 1'b1;
                     resv_addr_d  = mem_req_i.q.addr;
                  end
                  AMOSC: begin
                     // Only a successful SC reaches the SRAM as a write.
                     sram_we_o    = resv_hit_s;
                     sc_result_d  = ~resv_hit_s;
                     sel_sc_d     = 1'b1;
                     resv_valid_d = 1'b0;
                  end
                  AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
                  AMOMax, AMOMaxu, AMOMin, AMOMinu: begin
                     state_d       = Amo;
                     amo_addr_d    = mem_req_i.q.addr;
                     amo_strb_d    = mem_req_i.q.strb;
                     amo_operand_d = mem_req_i.q.data;
                     // An illegal width degrades to a strobe-masked swap.
                     if (req_lane_s == LaneBad) begin
                        amo_op_d   = AMOSwap;
                        amo_lane_d = LaneFull;
                     end else begin
                        amo_op_d   = mem_req_i.q.amo;
                        amo_lane_d = req_lane_s;
                     end
                  end
                  default: begin
                     sram_we_o = 1'b0;
                  end
               endcase
            end else begin
               state_d = Idle;
            end
         end
         Amo: begin
            // Write-back cycle; the port is busy so no request is accepted.
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = amo_addr_q;
            sram_wdata_o = alu_new_s;
            sram_be_o    = amo_strb_q;
            state_d      = Idle;
            if (resv_valid_q && (resv_addr_q == amo_addr_q)) begin
               resv_valid_d = 1'b0;
            end else begin
               resv_valid_d = resv_valid_q;
            end
         end
         default: begin
            state_d = Idle;
         end
      endcase
   end

   // Response: ready only in Idle; data is the SC result or the SRAM word.
   always_comb begin
      mem_rsp_o         = '0;
      mem_rsp_o.q_ready = (state_q == Idle);
      if (sel_sc_q) begin
         mem_rsp_o.p.data = {{(DataWidth-1){1'b0}}, sc_result_q};
      end else begin
         mem_rsp_o.p.data = sram_rdata_i;
      end
   end

   // State, reservation and AMO operand registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= Idle;
         resv_valid_q  <= 1'b0;
         resv_addr_q   <= '0;
         sc_result_q   <= 1'b0;
         sel_sc_q      <= 1'b0;
         amo_addr_q    <= '0;
         amo_strb_q    <= '0;
         amo_operand_q <= '0;
         amo_op_q      <= AMONone;
         amo_lane_q    <= LaneFull;
      end else begin
         state_q       <= state_d;
         resv_valid_q  <= resv_valid_d;
         resv_addr_q   <= resv_addr_d;
         sc_result_q   <= sc_result_d;
         sel_sc_q      <= sel_sc_d;
         amo_addr_q    <= amo_addr_d;
         amo_strb_q    <= amo_strb_d;
         amo_operand_q <= amo_operand_d;
         amo_op_q      <= amo_op_d;
         amo_lane_q    <= amo_lane_d;
      end
   end

endmodule

// File: tb/tb_spatz_tcdm_amo_bank.sv
// Self-checking bench for spatz_tcdm_amo_bank with a behavioural SRAM and a
// response scoreboard. Inputs change on the falling edge, outputs are sampled
// on the falling edge.
module tb_spatz_tcdm_amo_bank;
   import spatz_tcdm_pkg::*;

   logic        clk;
   logic        rst_n;
   mem_req_t    req;
   mem_rsp_t    rsp;
   logic        sram_req;
   logic        sram_we;
   logic [9:0]  sram_addr;
   logic [63:0] sram_wdata;
   logic [7:0]  sram_be;
   logic [63:0] sram_rdata;

   logic [63:0] sram_mem [1024];
   int          sram_writes;
   logic [63:0] exp_q [$];
   int          n_run;
   int          n_fail;

   spatz_tcdm_amo_bank dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mem_req_i    (req),
      .mem_rsp_o    (rsp),
      .sram_req_o   (sram_req),
      .sram_we_o    (sram_we),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .sram_be_o    (sram_be),
      .sram_rdata_i (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port SRAM with byte enables and 1-cycle read latency.
   always @(posedge clk) begin
      if (sram_req) begin
         if (sram_we) begin
            for (int b = 0; b < 8; b++) begin
               if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
            sram_writes <= sram_writes + 1;
         end
         sram_rdata <= sram_mem[sram_addr];
      end
   end

   // Drive one request from a falling edge; returns on the falling edge of the
   // response cycle with q_valid dropped.
   task automatic issue(input amo_op_e op, input logic [9:0] addr,
                        input logic [63:0] data, input logic [7:0] strb, input logic wr);
      int waited;
      req.q_valid = 1'b1;
      req.q.addr  = addr;
      req.q.write = wr;
      req.q.amo   = op;
      req.q.data  = data;
      req.q.strb  = strb;
      req.q.user  = 1'b0;
      waited = 0;
      while (!rsp.q_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (!rsp.q_ready) begin
         n_run++;
         n_fail++;
         $display("FAIL handshake_timeout: q_ready=%b required 1", rsp.q_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req.q_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      @(negedge clk);
      n_run++;
      if (rsp.q_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b required 1", rsp.q_ready);
      end
      n_run++;
      if ({sram_req, sram_we, sram_addr, sram_wdata, sram_be} !== 84'd0) begin
         n_fail++;
         $display("FAIL reset_sram: req=%b we=%b addr=%h wdata=%h be=%h required all 0",
                  sram_req, sram_we, sram_addr, sram_wdata, sram_be);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      logic [63:0] got, exp;
      req.q_valid = 1'b1;
      req.q.addr  = 10'd5;
      req.q.write = 1'b1;
      req.q.amo   = AMONone;
      req.q.data  = 64'hDEAD_BEEF_0123_4567;
      req.q.strb  = 8'hFF;
      #1;
      n_run++;
      if ({sram_req, sram_we, sram_addr, sram_be} !== {1'b1, 1'b1, 10'd5, 8'hFF}) begin
         n_fail++;
         $display("FAIL write_forward: req=%b we=%b addr=%0d be=%h required 1 1 5 ff",
                  sram_req, sram_we, sram_addr, sram_be);
      end
      @(posedge clk);
      @(negedge clk);
      req.q_valid = 1'b0;
      exp_q.push_back(64'hDEAD_BEEF_0123_4567);
      issue(AMONone, 10'd5, 64'd0, 8'hFF, 1'b0);
      got = rsp.p.data;
      exp = exp_q.pop_front();
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL read_back: got %h required %h", got, exp);
      end
   endtask

   task automatic test_amo_add();
      logic [63:0] exp;
      issue(AMONone, 10'd3, 64'h0000_0001_0000_0010, 8'hFF, 1'b1);
      exp_q.push_back(64'h0000_0001_0000_0010);
      issue(AMOAdd, 10'd3, 64'd5, 8'h0F, 1'b0);
      exp = exp_q.pop_front();
      n_run++;
      if (rsp.p.data !== exp) begin
         n_fail++;
         $display("FAIL amoadd_old: got %h required %h", rsp.p.data, exp);
      end
      n_run++;
      if (rsp.q_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL amoadd_busy: q_ready=%b required 0", rsp.q_ready);
      end
      @(negedge clk);
      n_run++;
      if (rsp.q_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL amoadd_ready_again: q_ready=%b required 1", rsp.q_ready);
      end
      n_run++;
      if (sram_mem[3] !== 64'h0000_0001_0000_0015) begin
         n_fail++;
         $display("FAIL amoadd_mem: got %h required 0000000100000015", sram_mem[3]);
      end
   endtask

   task automatic test_amo_minmax();
      // Signed max on the low lane: -2 vs 1 -> 1.
      issue(AMONone, 10'd7, 64'h1234_5678_FFFF_FFFE, 8'hFF, 1'b1);
      issue(AMOMax, 10'd7, 64'd1, 8'h0F, 1'b0);
      @(negedge clk);
      n_run++;
      if (sram_mem[7] !== 64'h1234_5678_0000_0001) begin
         n_fail++;
         $display("FAIL amomax_lo: got %h required 1234567800000001", sram_mem[7]);
      end
      // Unsigned max: 0xFFFFFFFE stays.
      issue(AMONone, 10'd7, 64'h1234_5678_FFFF_FFFE, 8'hFF, 1'b1);
      issue(AMOMaxu, 10'd7, 64'd1, 8'h0F, 1'b0);
      @(negedge clk);
      n_run++;
      if (sram_mem[7] !== 64'h1234_5678_FFFF_FFFE) begin
         n_fail++;
         $display("FAIL amomaxu_lo: got %h required 12345678fffffffe", sram_mem[7]);
      end
      // Signed min on the high lane: 5 vs -1 -> -1, low lane untouched.
      issue(AMONone, 10'd8, 64'h0000_0005_AAAA_AAAA, 8'hFF, 1'b1);
      exp_q.push_back(64'h0000_0005_AAAA_AAAA);
      issue(AMOMin, 10'd8, 64'hFFFF_FFFF_0000_0000, 8'hF0, 1'b0);
      n_run++;
      if (rsp.p.data !== exp_q[0]) begin
         n_fail++;
         $display("FAIL amomin_hi_old: got %h required %h", rsp.p.data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
      n_run++;
      if (sram_mem[8] !== 64'hFFFF_FFFF_AAAA_AAAA) begin
         n_fail++;
         $display("FAIL amomin_hi: got %h required ffffffffaaaaaaaa", sram_mem[8]);
      end
      // Unsigned min on the full word: 0x8000... vs 1 -> 1.
      issue(AMONone, 10'd11, 64'h8000_0000_0000_0000, 8'hFF, 1'b1);
      issue(AMOMinu, 10'd11, 64'd1, 8'hFF, 1'b0);
      @(negedge clk);
      n_run++;
      if (sram_mem[11] !== 64'd1) begin
         n_fail++;
         $display("FAIL amominu_64: got %h required 0000000000000001", sram_mem[11]);
      end
   endtask

   task automatic test_lrsc();
      logic [63:0] exp;
      issue(AMONone, 10'd9, 64'h77, 8'hFF, 1'b1);
      exp_q.push_back(64'h77);
      issue(AMOLR, 10'd9, 64'd0, 8'hFF, 1'b0);
      exp = exp_q.pop_front();
      n_run++;
      if (rsp.p.data !== exp) begin
         n_fail++;
         $display("FAIL lr_data: got %h required %h", rsp.p.data, exp);
      end
      exp_q.push_back(64'd0);
      issue(AMOSC, 10'd9, 64'h42, 8'hFF, 1'b0);
      exp = exp_q.pop_front();
      n_run++;
      if (rsp.p.data !== exp) begin
         n_fail++;
         $display("FAIL sc_ok_result: got %h required %h", rsp.p.data, exp);
      end
      n_run++;
      if (sram_mem[9] !== 64'h42) begin
         n_fail++;
         $display("FAIL sc_ok_mem: got %h required 42", sram_mem[9]);
      end
      exp_q.push_back(64'd1);
      issue(AMOSC, 10'd9, 64'h99, 8'hFF, 1'b0);
      exp = exp_q.pop_front();
      n_run++;
      if (rsp.p.data !== exp) begin
         n_fail++;
         $display("FAIL sc_again_result: got %h required %h", rsp.p.data, exp);
      end
      n_run++;
      if (sram_mem[9] !== 64'h42) begin
         n_fail++;
         $display("FAIL sc_again_nowrite: got %h required 42", sram_mem[9]);
      end
   endtask

   task automatic test_resv_clear();
      logic [63:0] exp;
      // Plain write to the reserved address kills the reservation.
      issue(AMOLR, 10'd9, 64'd0, 8'hFF, 1'b0);
      issue(AMONone, 10'd9, 64'h1234, 8'hFF, 1'b1);
      exp_q.push_back(64'd1);
      issue(AMOSC, 10'd9, 64'h55, 8'hFF, 1'b0);
      exp = exp_q.pop_front();
      n_run++;
      if (rsp.p.data !== exp) begin
         n_fail++;
         $display("FAIL sc_after_write_result: got %h required %h", rsp.p.data, exp);
      end
      n_run++;
      if (sram_mem[9] !== 64'h1234) begin
         n_fail++;
         $display("FAIL sc_after_write_mem: got %h required 1234", sram_mem[9]);
      end
      // Write elsewhere leaves it intact.
      issue(AMOLR, 10'd9, 64'd0, 8'hFF, 1'b0);
      issue(AMONone, 10'd10, 64'h66, 8'hFF, 1'b1);
      exp_q.push_back(64'd0);
      issue(AMOSC, 10'd9, 64'h77, 8'hFF, 1'b0);
      exp = exp_q.pop_front();
      n_run++;
      if (rsp.p.data !== exp) begin
         n_fail++;
         $display("FAIL sc_other_addr_result: got %h required %h", rsp.p.data, exp);
      end
      n_run++;
      if (sram_mem[9] !== 64'h77) begin
         n_fail++;
         $display("FAIL sc_other_addr_mem: got %h required 77", sram_mem[9]);
      end
      // AMO write-back to the reserved address also kills it.
      issue(AMOLR, 10'd9, 64'd0, 8'hFF, 1'b0);
      issue(AMOAdd, 10'd9, 64'd1, 8'hFF, 1'b0);
      @(negedge clk);
      exp_q.push_back(64'd1);
      issue(AMOSC, 10'd9, 64'h5, 8'hFF, 1'b0);
      exp = exp_q.pop_front();
      n_run++;
      if (rsp.p.data !== exp) begin
         n_fail++;
         $display("FAIL sc_after_amo_result: got %h required %h", rsp.p.data, exp);
      end
      n_run++;
      if (sram_mem[9] !== 64'h78) begin
         n_fail++;
         $display("FAIL sc_after_amo_mem: got %h required 78", sram_mem[9]);
      end
   endtask

   task automatic test_back_to_back();
      int          accepted;
      logic        resp_pending;
      logic        hs;
      int          hs_cycle [$];
      logic [63:0] exp;
      issue(AMONone, 10'd20, 64'd100, 8'hFF, 1'b1);
      req.q_valid = 1'b1;
      req.q.addr  = 10'd20;
      req.q.write = 1'b0;
      req.q.amo   = AMOAdd;
      req.q.data  = 64'd1;
      req.q.strb  = 8'hFF;
      accepted     = 0;
      resp_pending = 1'b0;
      for (int c = 0; c < 20 && !(accepted == 4 && !resp_pending); c++) begin
         if (resp_pending) begin
            exp = exp_q.pop_front();
            n_run++;
            if (rsp.p.data !== exp) begin
               n_fail++;
               $display("FAIL b2b_rsp: got %h required %h", rsp.p.data, exp);
            end
         end
         hs = rsp.q_ready && req.q_valid;
         if (hs) begin
            exp_q.push_back(64'd100 + 64'(accepted));
            hs_cycle.push_back(c);
            accepted++;
         end
         @(posedge clk);
         resp_pending = hs;
         @(negedge clk);
         if (accepted == 4) req.q_valid = 1'b0;
      end
      req.q_valid = 1'b0;
      n_run++;
      if (accepted != 4) begin
         n_fail++;
         $display("FAIL b2b_accepted: got %0d required 4", accepted);
      end
      for (int i = 0; i + 1 < hs_cycle.size(); i++) begin
         n_run++;
         if (hs_cycle[i+1] - hs_cycle[i] != 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles required 2", hs_cycle[i+1] - hs_cycle[i]);
         end
      end
      n_run++;
      if (sram_mem[20] !== 64'd104) begin
         n_fail++;
         $display("FAIL b2b_mem: got %0d required 104", sram_mem[20]);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_amo();
      int          writes_before;
      logic [63:0] exp;
      issue(AMONone, 10'd40, 64'd0, 8'hFF, 1'b1);
      issue(AMONone, 10'd30, 64'h10, 8'hFF, 1'b1);
      issue(AMOLR, 10'd40, 64'd0, 8'hFF, 1'b0);
      writes_before = sram_writes;
      exp_q.push_back(64'h10);
      issue(AMOAdd, 10'd30, 64'd1, 8'hFF, 1'b0);
      exp = exp_q.pop_front();
      n_run++;
      if (rsp.p.data !== exp) begin
         n_fail++;
         $display("FAIL rstamo_old: got %h required %h", rsp.p.data, exp);
      end
      rst_n = 1'b0;
      #1;
      n_run++;
      if (sram_we !== 1'b0 || rsp.q_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstamo_outputs: we=%b q_ready=%b required 0 1", sram_we, rsp.q_ready);
      end
      @(negedge clk);
      n_run++;
      if (sram_writes != writes_before || sram_mem[30] !== 64'h10) begin
         n_fail++;
         $display("FAIL rstamo_nowrite: writes=%0d mem=%h required %0d 10",
                  sram_writes - writes_before, sram_mem[30], 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.push_back(64'd1);
      issue(AMOSC, 10'd40, 64'h5, 8'hFF, 1'b0);
      exp = exp_q.pop_front();
      n_run++;
      if (rsp.p.data !== exp || sram_mem[40] !== 64'd0) begin
         n_fail++;
         $display("FAIL rstamo_resv: sc=%h mem=%h required 1 0", rsp.p.data, sram_mem[40]);
      end
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      test_reset();
      test_write_read();
      test_amo_add();
      test_amo_minmax();
      test_lrsc();
      test_resv_clear();
      test_back_to_back();
      test_reset_mid_amo();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
